display_panel_receiver: RTL and testbench

//  SPI-slave model of the ILI9341-class panel driven by display_controller through the SPI master.

---
 rtl/display_panel_receiver.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_display_panel_receiver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_panel_receiver.sv
// display_panel_receiver
//   SPI-slave model of an ILI9341-class panel. Deserialises sclk/mosi/cs_n/dc
//   into bytes, decodes the command subset issued by display_controller, tracks
//   panel state and the column/page windows, and emits RGB565 pixel writes
//   during RAMWR. Any protocol or timing violation raises a one-cycle err pulse.
//
// Ports
//   clk, reset            system clock (>= 4x sclk), synchronous active-high reset
//   dis_reset             panel hardware reset, active-high, synchronised internally
//   sclk, mosi, cs_n, dc  SPI mode 0 slave inputs (dc sampled with bit 0)
//   rx_valid/rx_byte/rx_dc       received byte strobe, value and dc flag
//   pxl_valid/pxl_x/pxl_y/pxl_data  pixel write strobe, coordinates, {hi,lo}
//   frame_done            pulses with the pixel at (col_end, page_end)
//   sleep_out, display_on panel state flags set by SLPOUT / DISPON
//   pxl_fmt, madctl       COLMOD / MADCTL parameters
//   err                   one-cycle violation pulse
module display_panel_receiver #(
    parameter int DIS_RES_X       = 240,
    parameter int DIS_RES_Y       = 320,
    parameter int SW_RESET_TIMER  = 4,
    parameter int SLEEP_OUT_TIMER = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dis_reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    input  logic        dc,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_dc,
    output logic        pxl_valid,
    output logic [15:0] pxl_x,
    output logic [15:0] pxl_y,
    output logic [15:0] pxl_data,
    output logic        frame_done,
    output logic        sleep_out,
    output logic        display_on,
    output logic [7:0]  pxl_fmt,
    output logic [7:0]  madctl,
    output logic        err
);

    localparam logic [7:0]  CMD_SWRESET = 8'h01;
    localparam logic [7:0]  CMD_SLPOUT  = 8'h11;
    localparam logic [7:0]  CMD_DISPON  = 8'h29;
    localparam logic [7:0]  CMD_CASET   = 8'h2A;
    localparam logic [7:0]  CMD_PASET   = 8'h2B;
    localparam logic [7:0]  CMD_RAMWR   = 8'h2C;
    localparam logic [7:0]  CMD_MADCTL  = 8'h36;
    localparam logic [7:0]  CMD_COLMOD  = 8'h3A;
    localparam logic [7:0]  FMT_RST     = 8'h66;
    localparam logic [7:0]  FMT_RGB565  = 8'h55;

    localparam logic [15:0] COL_END_RST  = 16'(DIS_RES_X - 1);
    localparam logic [15:0] PAGE_END_RST = 16'(DIS_RES_Y - 1);
    localparam logic [15:0] SW_TMR_LOAD  = 16'(SW_RESET_TIMER);
    localparam logic [15:0] SLP_TMR_LOAD = 16'(SLEEP_OUT_TIMER);

    // Synchroniser bit order {dis_reset, cs_n, dc, mosi, sclk}; idle = cs_n high.
    localparam logic [4:0]  SYNC_IDLE = 5'b01000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARAM,
        ST_RAMWR_HI,
        ST_RAMWR_LO,
        ST_DISCARD
    } state_t;

    logic [4:0]  sync_p0;
    logic [4:0]  sync_p1;
    logic        sclk_p2;
    logic        sclk_rise;
    logic        mosi_s;
    logic        dc_s;
    logic        cs_s;
    logic        dis_rst_s;
    logic        reg_rst;

    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  param_cmd;
    logic [1:0]  param_idx;
    logic        param_last;
    logic [7:0]  prm_b0;
    logic [7:0]  prm_b1;
    logic [7:0]  prm_b2;
    logic [7:0]  pxl_hi;

    logic [15:0] col_start;
    logic [15:0] col_end;
    logic [15:0] page_start;
    logic [15:0] page_end;
    logic [15:0] cur_x;
    logic [15:0] cur_y;
    logic [15:0] sw_tmr;
    logic [15:0] slp_tmr;

    logic        blackout;
    logic        ramwr_bad;
    logic        at_col_end;
    logic        at_frame_end;

    logic        err_nxt;
    logic        do_swreset;
    logic        do_slpout;
    logic        do_dispon;
    logic        start_param;
    logic        store_param;
    logic        do_ramwr;
    logic        hold_hi;
    logic        emit_pxl;

    // ---- stage p0/p1: two-flop input synchronisers, p2: sclk edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= SYNC_IDLE;
            sync_p1 <= SYNC_IDLE;
            sclk_p2 <= 1'b0;
        end else begin
            sync_p0 <= {dis_reset, cs_n, dc, mosi, sclk};
            sync_p1 <= sync_p0;
            sclk_p2 <= sync_p1[0];
        end
    end

    assign sclk_rise = sync_p1[0] & ~sclk_p2;
    assign mosi_s    = sync_p1[1];
    assign dc_s      = sync_p1[2];
    assign cs_s      = sync_p1[3];
    assign dis_rst_s = sync_p1[4];
    assign reg_rst   = reset | dis_rst_s;

    // ---- deserialiser: 8th rising edge registers the byte into rx_*
    always_ff @(posedge clk) begin
        if (!cs_s && sclk_rise) begin
            shreg <= {shreg[5:0], mosi_s};
        end
    end

    always_ff @(posedge clk) begin
        if (reg_rst) begin
            bit_cnt  <= 3'd0;
            rx_valid <= 1'b0;
            rx_byte  <= 8'h00;
            rx_dc    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_s) begin
                // Deselect drops any partial byte; decode state is untouched.
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_byte  <= {shreg, mosi_s};
                    rx_dc    <= dc_s;
                end
            end
        end
    end

    // ---- decode: evaluated in the rx_valid cycle, effects land one cycle later
    assign blackout     = (sw_tmr != 16'd0) || (slp_tmr != 16'd0);
    assign ramwr_bad    = (pxl_fmt != FMT_RGB565) || (col_start > col_end) ||
                          (page_start > page_end) || !sleep_out;
    assign param_last   = ((param_cmd == CMD_COLMOD) || (param_cmd == CMD_MADCTL)) ?
                          (param_idx == 2'd0) : (param_idx == 2'd3);
    assign at_col_end   = (cur_x == col_end);
    assign at_frame_end = at_col_end && (cur_y == page_end);

    always_comb begin
        state_nxt   = state;
        err_nxt     = 1'b0;
        do_swreset  = 1'b0;
        do_slpout   = 1'b0;
        do_dispon   = 1'b0;
        start_param = 1'b0;
        store_param = 1'b0;
        do_ramwr    = 1'b0;
        hold_hi     = 1'b0;
        emit_pxl    = 1'b0;
        if (rx_valid) begin
            if (blackout) begin
                err_nxt = 1'b1;
            end else if (!rx_dc) begin
                // Commands are honoured in every state and abandon any partial parameter set.
                case (rx_byte)
                    CMD_SWRESET: begin
                        do_swreset = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                    CMD_SLPOUT: begin
                        do_slpout = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                    CMD_DISPON: begin
                        do_dispon = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                    CMD_COLMOD, CMD_MADCTL, CMD_CASET, CMD_PASET: begin
                        start_param = 1'b1;
                        state_nxt   = ST_PARAM;
                    end
                    CMD_RAMWR: begin
                        do_ramwr = 1'b1;
                        if (ramwr_bad) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_DISCARD;
                        end else begin
                            state_nxt = ST_RAMWR_HI;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: err_nxt = 1'b1;
                    ST_PARAM: begin
                        store_param = 1'b1;
                        if (param_last) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_RAMWR_HI: begin
                        hold_hi   = 1'b1;
                        state_nxt = ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        emit_pxl  = 1'b1;
                        state_nxt = ST_RAMWR_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reg_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parameter and pixel-high holding registers carry data only.
    always_ff @(posedge clk) begin
        if (store_param) begin
            case (param_idx)
                2'd0:    prm_b0 <= rx_byte;
                2'd1:    prm_b1 <= rx_byte;
                2'd2:    prm_b2 <= rx_byte;
                default: ;
            endcase
        end
        if (hold_hi) begin
            pxl_hi <= rx_byte;
        end
    end

    // ---- panel state, windows, raster position and blackout timers
    always_ff @(posedge clk) begin
        if (reg_rst || do_swreset) begin
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
            pxl_fmt    <= FMT_RST;
            madctl     <= 8'h00;
            col_start  <= 16'd0;
            col_end    <= COL_END_RST;
            page_start <= 16'd0;
            page_end   <= PAGE_END_RST;
            cur_x      <= 16'd0;
            cur_y      <= 16'd0;
            param_cmd  <= 8'h00;
            param_idx  <= 2'd0;
            slp_tmr    <= 16'd0;
            // A hardware reset wins over a SWRESET completing in the same cycle.
            sw_tmr     <= reg_rst ? 16'd0 : SW_TMR_LOAD;
        end else begin
            if (sw_tmr != 16'd0) begin
                sw_tmr <= sw_tmr - 16'd1;
            end
            if (slp_tmr != 16'd0) begin
                slp_tmr <= slp_tmr - 16'd1;
            end
            if (do_slpout) begin
                sleep_out <= 1'b1;
                slp_tmr   <= SLP_TMR_LOAD;
            end
            if (do_dispon) begin
                display_on <= 1'b1;
            end
            if (start_param) begin
                param_cmd <= rx_byte;
                param_idx <= 2'd0;
            end
            if (store_param) begin
                param_idx <= param_idx + 2'd1;
                if (param_last) begin
                    case (param_cmd)
                        CMD_COLMOD: pxl_fmt <= rx_byte;
                        CMD_MADCTL: madctl  <= rx_byte;
                        CMD_CASET: begin
                            col_start <= {prm_b0, prm_b1};
                            col_end   <= {prm_b2, rx_byte};
                        end
                        CMD_PASET: begin
                            page_start <= {prm_b0, prm_b1};
                            page_end   <= {prm_b2, rx_byte};
                        end
                        default: ;
                    endcase
                end
            end
            if (do_ramwr) begin
                cur_x <= col_start;
                cur_y <= page_start;
            end
            if (emit_pxl) begin
                // Inclusive window: x never passes col_end, so no overflow guard is needed.
                if (at_col_end) begin
                    cur_x <= col_start;
                    cur_y <= (cur_y == page_end) ? page_start : cur_y + 16'd1;
                end else begin
                    cur_x <= cur_x + 16'd1;
                end
            end
        end
    end

    // ---- output stage: pixel and error strobes, one cycle after rx_valid
    always_ff @(posedge clk) begin
        if (reg_rst) begin
            err        <= 1'b0;
            pxl_valid  <= 1'b0;
            frame_done <= 1'b0;
            pxl_x      <= 16'd0;
            pxl_y      <= 16'd0;
            pxl_data   <= 16'd0;
        end else begin
            err        <= err_nxt;
            pxl_valid  <= emit_pxl;
            frame_done <= emit_pxl && at_frame_end;
            if (emit_pxl) begin
                pxl_x    <= cur_x;
                pxl_y    <= cur_y;
                pxl_data <= {pxl_hi, rx_byte};
            end
        end
    end

endmodule

// File: tb/tb_display_panel_receiver.sv
module tb_display_panel_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dis_reset = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        dc = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_dc;
    logic        pxl_valid;
    logic [15:0] pxl_x;
    logic [15:0] pxl_y;
    logic [15:0] pxl_data;
    logic        frame_done;
    logic        sleep_out;
    logic        display_on;
    logic [7:0]  pxl_fmt;
    logic [7:0]  madctl;
    logic        err;

    int checks = 0;
    int failures = 0;

    int          rxv_cnt = 0;
    int          err_cnt = 0;
    int          stray_fd = 0;
    logic [7:0]  last_rx_byte = 8'h00;
    logic        last_rx_dc = 1'b0;
    logic [15:0] q_x[$];
    logic [15:0] q_y[$];
    logic [15:0] q_d[$];
    logic        q_fd[$];

    // A byte takes ~40 clk, so the SWRESET blackout is stretched to cover one back-to-back byte.
    display_panel_receiver #(
        .DIS_RES_X(240),
        .DIS_RES_Y(320),
        .SW_RESET_TIMER(48),
        .SLEEP_OUT_TIMER(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dis_reset(dis_reset),
        .sclk(sclk),
        .mosi(mosi),
        .cs_n(cs_n),
        .dc(dc),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .rx_dc(rx_dc),
        .pxl_valid(pxl_valid),
        .pxl_x(pxl_x),
        .pxl_y(pxl_y),
        .pxl_data(pxl_data),
        .frame_done(frame_done),
        .sleep_out(sleep_out),
        .display_on(display_on),
        .pxl_fmt(pxl_fmt),
        .madctl(madctl),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            last_rx_byte = rx_byte;
            last_rx_dc = rx_dc;
        end
        if (err) err_cnt++;
        if (pxl_valid) begin
            q_x.push_back(pxl_x);
            q_y.push_back(pxl_y);
            q_d.push_back(pxl_data);
            q_fd.push_back(frame_done);
        end
        if (frame_done && !pxl_valid) stray_fd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b, input logic d);
        logic [7:0] v;
        v = b;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            mosi = v[i];
            dc = d;
            idle(2);
            sclk = 1'b1;
            idle(2);
            sclk = 1'b0;
        end
        idle(6);
    endtask

    task automatic clear_px();
        q_x.delete();
        q_y.delete();
        q_d.delete();
        q_fd.delete();
    endtask

    task automatic test_reset();
        int n0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        checks++; if ({rx_valid, pxl_valid, frame_done, err, sleep_out, display_on} !== 6'b0)
            begin failures++; $display("FAIL reset_flags got=%b want=000000", {rx_valid, pxl_valid, frame_done, err, sleep_out, display_on}); end
        checks++; if (pxl_fmt !== 8'h66) begin failures++; $display("FAIL reset_pxl_fmt got=%h want=66", pxl_fmt); end
        checks++; if (madctl !== 8'h00) begin failures++; $display("FAIL reset_madctl got=%h want=00", madctl); end
        checks++; if ({rx_byte, rx_dc, pxl_x, pxl_y, pxl_data} !== 57'd0)
            begin failures++; $display("FAIL reset_data got=%h want=0", {rx_byte, rx_dc, pxl_x, pxl_y, pxl_data}); end
        n0 = rxv_cnt;
        spi_byte(8'h01, 1'b0);
        checks++; if (rxv_cnt - n0 != 1) begin failures++; $display("FAIL rx_count got=%0d want=1", rxv_cnt - n0); end
        checks++; if (last_rx_byte !== 8'h01) begin failures++; $display("FAIL rx_byte got=%h want=01", last_rx_byte); end
        checks++; if (last_rx_dc !== 1'b0) begin failures++; $display("FAIL rx_dc got=%b want=0", last_rx_dc); end
    endtask

    task automatic test_blackout();
        int e0;
        e0 = err_cnt;
        spi_byte(8'h11, 1'b0);
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL blackout_err got=%0d want=1", err_cnt - e0); end
        checks++; if (sleep_out !== 1'b0) begin failures++; $display("FAIL blackout_drop sleep_out got=%b want=0", sleep_out); end
        idle(80);
        spi_byte(8'h01, 1'b0);
        idle(80);
        e0 = err_cnt;
        spi_byte(8'h11, 1'b0);
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL after_blackout_err got=%0d want=0", err_cnt - e0); end
        checks++; if (sleep_out !== 1'b1) begin failures++; $display("FAIL slpout got=%b want=1", sleep_out); end
        idle(120);
    endtask

    task automatic test_regs();
        int e0;
        e0 = err_cnt;
        spi_byte(8'h29, 1'b0);
        checks++; if (display_on !== 1'b1) begin failures++; $display("FAIL dispon got=%b want=1", display_on); end
        spi_byte(8'h36, 1'b0);
        spi_byte(8'hA5, 1'b1);
        checks++; if (madctl !== 8'hA5) begin failures++; $display("FAIL madctl got=%h want=a5", madctl); end
        spi_byte(8'h3A, 1'b0);
        spi_byte(8'h55, 1'b1);
        checks++; if (pxl_fmt !== 8'h55) begin failures++; $display("FAIL colmod got=%h want=55", pxl_fmt); end
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL regs_err got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_frame();
        int e0;
        logic [48:0] got;
        logic [48:0] exp;
        e0 = err_cnt;
        spi_byte(8'h2A, 1'b0);
        spi_byte(8'h00, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h03, 1'b1);
        spi_byte(8'h2B, 1'b0);
        spi_byte(8'h00, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h02, 1'b1);
        spi_byte(8'h2C, 1'b0);
        clear_px();
        stray_fd = 0;
        for (int i = 0; i < 12; i++) begin
            spi_byte(8'hF8, 1'b1);
            spi_byte(8'h00, 1'b1);
        end
        checks++; if (q_x.size() != 12) begin failures++; $display("FAIL frame_count got=%0d want=12", q_x.size()); end
        for (int i = 0; i < 12 && i < q_x.size(); i++) begin
            got = {q_x[i], q_y[i], q_d[i], q_fd[i]};
            exp = {16'(i % 4), 16'(i / 4), 16'hF800, (i == 11)};
            checks++; if (got !== exp) begin failures++; $display("FAIL frame_pixel%0d got=%h want=%h", i, got, exp); end
        end
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL frame_err got=%0d want=0", err_cnt - e0); end
        checks++; if (stray_fd != 0) begin failures++; $display("FAIL frame_done_stray got=%0d want=0", stray_fd); end
    endtask

    task automatic test_window_abort();
        int e0;
        logic [48:0] got;
        logic [48:0] exp;
        e0 = err_cnt;
        spi_byte(8'h2A, 1'b0);
        spi_byte(8'h00, 1'b1); spi_byte(8'h05, 1'b1);
        spi_byte(8'h2B, 1'b0);
        spi_byte(8'h00, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h00, 1'b1); spi_byte(8'h01, 1'b1);
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL abort_err got=%0d want=0", err_cnt - e0); end
        spi_byte(8'h2C, 1'b0);
        clear_px();
        for (int i = 0; i < 8; i++) begin
            spi_byte(8'h12, 1'b1);
            spi_byte(8'h34, 1'b1);
        end
        checks++; if (q_x.size() != 8) begin failures++; $display("FAIL window_count got=%0d want=8", q_x.size()); end
        for (int i = 0; i < 8 && i < q_x.size(); i++) begin
            got = {q_x[i], q_y[i], q_d[i], q_fd[i]};
            exp = {16'(i % 4), 16'(i / 4), 16'h1234, (i == 7)};
            checks++; if (got !== exp) begin failures++; $display("FAIL window_pixel%0d got=%h want=%h", i, got, exp); end
        end
    endtask

    task automatic test_ramwr_bad();
        int e0;
        spi_byte(8'h3A, 1'b0);
        spi_byte(8'h66, 1'b1);
        e0 = err_cnt;
        spi_byte(8'h2C, 1'b0);
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL ramwr_fmt_err got=%0d want=1", err_cnt - e0); end
        clear_px();
        for (int i = 0; i < 4; i++) spi_byte(8'hFF, 1'b1);
        checks++; if (q_x.size() != 0) begin failures++; $display("FAIL discard_pixels got=%0d want=0", q_x.size()); end
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL discard_err got=%0d want=1", err_cnt - e0); end
    endtask

    task automatic test_dis_reset();
        int e0;
        spi_byte(8'h3A, 1'b0);
        spi_byte(8'h55, 1'b1);
        spi_byte(8'h2C, 1'b0);
        clear_px();
        spi_byte(8'hAB, 1'b1);
        dis_reset = 1'b1;
        idle(4);
        dis_reset = 1'b0;
        idle(4);
        checks++; if ({sleep_out, display_on} !== 2'b00) begin failures++; $display("FAIL disrst_flags got=%b want=00", {sleep_out, display_on}); end
        checks++; if (pxl_fmt !== 8'h66) begin failures++; $display("FAIL disrst_pxl_fmt got=%h want=66", pxl_fmt); end
        e0 = err_cnt;
        spi_byte(8'hCD, 1'b1);
        checks++; if (q_x.size() != 0) begin failures++; $display("FAIL disrst_pixels got=%0d want=0", q_x.size()); end
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL disrst_data_err got=%0d want=1", err_cnt - e0); end
    endtask

    task automatic test_cs_abort();
        int n0;
        int e0;
        n0 = rxv_cnt;
        e0 = err_cnt;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            dc = 1'b0;
            idle(2);
            sclk = 1'b1;
            idle(2);
            sclk = 1'b0;
        end
        idle(2);
        cs_n = 1'b1;
        idle(6);
        spi_byte(8'h00, 1'b0);
        checks++; if (rxv_cnt - n0 != 1) begin failures++; $display("FAIL cs_abort_count got=%0d want=1", rxv_cnt - n0); end
        checks++; if (last_rx_byte !== 8'h00) begin failures++; $display("FAIL cs_abort_byte got=%h want=00", last_rx_byte); end
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL cs_abort_err got=%0d want=0", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_blackout();
        test_regs();
        test_frame();
        test_window_abort();
        test_ramwr_bad();
        test_dis_reset();
        test_cs_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
